i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) that presents a small 16-bit register file on the bus at a fixed 7-bit address, modelled on the pointer-register scheme of the ADS1115. It is the bus-side counterpart of our I2C initiator. It serves as an on-chip device model for closed-loop bench tests, and as a target port for an external host. Local logic supplies the conversion result; the bus writes the configuration and threshold registers.

## Interface
- `ADDR`, default 7'h48: 7-bit target address the block responds to.
- `clk`  in  1: system clock; must be ≥ 16× SCL frequency.
- `reset`  in  1: synchronous, active-high.
- `scl_i`  in  1: raw SCL from the pad. The target never stretches the clock.
- `sda_i`  in  1: raw SDA from the pad.
- `sda_oe`  out  1: 1 = pull SDA low. The pad is open-drain and the line is released when 0.
- `conv_data`  in  16: new conversion value for register 0.
- `conv_valid`  in  1: single-cycle strobe that loads `conv_data` into register 0.
- `cfg_reg`  out  16: register 1 (config); reset value 16'h8583.
- `lo_thresh`  out  16: register 2; reset value 16'h8000.
- `hi_thresh`  out  16: register 3; reset value 16'h7FFF.
- `wr_strobe`  out  1: one-cycle pulse when a 16-bit register write completes.
- `wr_ptr`  out  2: index of the written register; valid with `wr_strobe`.
- `busy`  out  1: 1 from START to STOP while addressed.

## Operation
- **Synchronizers.** `scl_i` and `sda_i` each pass through a 2-flop synchronizer, followed by a delayed copy for edge detection. All bus decisions use the synchronized signals.
- **START:** SDA falls while SCL is high. **STOP:** SDA rises while SCL is high.
  - Either condition is valid in any state.
  - START or repeated START → ADDR, with bit counter = 7.
  - STOP → IDLE with `sda_oe` = 0.
- **Bus timing.** SDA is sampled on the SCL rising edge. `sda_oe` changes only on the SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - **ADDR:** shift 8 bits, MSB first (7 address bits + R/W).
    - Address match: drive ACK (`sda_oe` = 1) for the 9th clock. Go to PTR if R/W = 0, or RDATA if R/W = 1.
    - Address mismatch: go to IGNORE, with no ACK, until the next START or STOP.
  - **PTR:** first byte after a write address. `ptr` ← byte[1:0]; bits [7:2] are ignored. ACK the byte, clear `half` (byte-select), then go to WDATA.
  - **WDATA:** first byte → `shadow[15:8]`; second byte → commit `{shadow[15:8], byte}` to reg[`ptr`]. Every byte is ACKed.
    - On commit, pulse `wr_strobe` with `wr_ptr` = `ptr`. Further bytes continue into the same `ptr`, alternating MSB then LSB.
    - Writes to `ptr` = 0 are ACKed and pulse `wr_strobe`, but register 0 is read-only and is not modified.
    - If STOP arrives after only the MSB byte, no commit occurs.
  - **RDATA:** on entry, latch a 16-bit snapshot of reg[`ptr`].
    - Drive the MSB byte, then the LSB byte, then repeat with a fresh snapshot. A data bit of 0 → `sda_oe` = 1.
    - RDATA_ACK releases SDA and samples the master's ACK. ACK (0) → next byte. NACK (1) → IGNORE until STOP or START.
- **`conv_valid` collision.** When `conv_valid` coincides with an in-progress read of register 0, the update goes to the register but not to the current snapshot. The 16-bit read is therefore always coherent.
- **Pointer retention.** `ptr` persists across transactions, so a write-address + pointer + repeated START + read sequence reads the selected register.

## Timing
- **Reset values:** `sda_oe` = 0, `busy` = 0, `wr_strobe` = 0, `wr_ptr` = 0, `ptr` = 0, reg0 = 0; `cfg_reg`, `lo_thresh`, `hi_thresh` take the values listed above. State = IDLE.
- **Edge-detect latency:** 3 clk from the pad edge.
- **`sda_oe` update:** within 1 clk after the detected SCL fall. That gives ≥ 5 clk of setup before the next SCL rise at 16× oversampling.
- **ACK release:** `sda_oe` releases on the SCL fall that ends the ACK clock.
- **Write commit:** `wr_strobe` asserts 1 clk after the SCL rise that samples the LSB bit 0. Register outputs update in the same cycle.
- **`busy`:** rises 1 clk after a matched address ACK begins, and falls 1 clk after STOP is detected.
- **Reset mid-transfer:** SDA is released immediately (next clk). The bus master then sees NACK or arbitration loss.
- **Glitches:** none are filtered beyond the synchronizer. SCL pulses shorter than 2 clk may be missed; this is acceptable.

## Test plan
- **Write cfg:** START, 0x90, 0x01, 0x84, 0x83, STOP → three ACKs plus ACK on data; `cfg_reg` = 16'h8483; one `wr_strobe` with `wr_ptr` = 1.
- **Read conversion:** pulse `conv_valid` with 16'h1234, then write pointer 0x00, repeated START, 0x91, read 2 bytes (ACK, then NACK), STOP → bytes 0x12, 0x34; `busy` low after STOP.
- **Wrong address:** START, 0xA0 → no ACK (SDA high at the 9th clock); `sda_oe` stays 0 until STOP; registers unchanged.
- **Partial write:** write ptr 2, then 0x55, then STOP → `lo_thresh` stays 16'h8000; no `wr_strobe`.
- **Snapshot coherence:** read reg0 = 16'hAAAA; `conv_valid` with 16'h5555 between the MSB and LSB bytes → bytes 0xAA, 0xAA; the next read returns 0x55, 0x55.
- **Reset mid-read:** assert `reset` while driving a 0 bit → `sda_oe` = 0 next clk; all outputs return to their reset values.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs
//   I2C target presenting four 16-bit registers at a fixed 7-bit address,
//   using an ADS1115-style pointer register. Register 0 holds the latest
//   conversion result (loaded locally, read-only from the bus); registers
//   1..3 are config, low threshold and high threshold (bus writable).
//
// Ports
//   clk, reset    system clock (>= 16x SCL) and synchronous active-high reset
//   scl_i, sda_i  raw bus lines from the pads
//   sda_oe        1 = pull SDA low (open-drain pad)
//   conv_data     new conversion value, loaded into register 0 on conv_valid
//   conv_valid    single-cycle load strobe for conv_data
//   cfg_reg       register 1
//   lo_thresh     register 2
//   hi_thresh     register 3
//   wr_strobe     one-cycle pulse when a 16-bit bus write completes
//   wr_ptr        register index of that write
//   busy          high from an addressed START until STOP
module i2c_target_regs #(
  parameter logic [6:0] ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] conv_data,
  input  logic        conv_valid,
  output logic [15:0] cfg_reg,
  output logic [15:0] lo_thresh,
  output logic [15:0] hi_thresh,
  output logic        wr_strobe,
  output logic [1:0]  wr_ptr,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t state, next_state;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic [7:0]  shift;
  logic [7:0]  rx_byte;
  logic [1:0]  ptr;
  logic        half;
  logic [7:0]  shadow;
  logic [15:0] snapshot;
  logic [15:0] reg0;
  logic [15:0] rd_val;
  logic [7:0]  tx_byte;
  logic        master_nack;

  // Synchronizers reset to the idle-bus level so leaving reset never
  // fabricates a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign rx_byte = {shift[6:0], sda_s2};
  assign tx_byte = half ? snapshot[7:0] : snapshot[15:8];

  always_comb begin
    rd_val = reg0;
    case (ptr)
      2'd1:    rd_val = cfg_reg;
      2'd2:    rd_val = lo_thresh;
      2'd3:    rd_val = hi_thresh;
      default: rd_val = reg0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Byte states advance on the SCL fall after their 8th bit; ACK states
  // advance on the fall that closes the 9th clock.
  always_comb begin
    next_state = state;
    if (start_det) begin
      next_state = S_ADDR;
    end else if (stop_det) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_ADDR:      if (scl_fall && byte_done)
                       next_state = (shift[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall) next_state = shift[0] ? S_RDATA : S_PTR;
        S_PTR:       if (scl_fall && byte_done) next_state = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall) next_state = S_WDATA;
        S_WDATA:     if (scl_fall && byte_done) next_state = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall) next_state = S_WDATA;
        S_RDATA:     if (scl_fall && bit_cnt == 3'd0) next_state = S_RDATA_ACK;
        S_RDATA_ACK: if (scl_fall) next_state = master_nack ? S_IGNORE : S_RDATA;
        default:     next_state = state;
      endcase
    end
  end

  // Datapath. Receive states shift on SCL rise; every change of sda_oe
  // happens on an SCL fall so the line only moves while SCL is low.
  // A write commits on the rise that samples the LSB bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_ptr      <= 2'd0;
      ptr         <= 2'd0;
      half        <= 1'b0;
      shadow      <= 8'h00;
      snapshot    <= 16'h0000;
      shift       <= 8'h00;
      bit_cnt     <= 3'd7;
      byte_done   <= 1'b0;
      master_nack <= 1'b1;
      reg0        <= 16'h0000;
      cfg_reg     <= 16'h8583;
      lo_thresh   <= 16'h8000;
      hi_thresh   <= 16'h7FFF;
    end else begin
      wr_strobe <= 1'b0;
      if (conv_valid) reg0 <= conv_data;

      if (state == S_ADDR_ACK)  busy <= 1'b1;
      else if (state == S_IDLE) busy <= 1'b0;

      if (start_det) begin
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && !byte_done) begin
              shift <= rx_byte;
              if (bit_cnt == 3'd0) begin
                byte_done <= 1'b1;
                if (state == S_WDATA) begin
                  half <= ~half;
                  if (!half) begin
                    shadow <= rx_byte;
                  end else begin
                    wr_strobe <= 1'b1;
                    wr_ptr    <= ptr;
                    if (ptr == 2'd1) cfg_reg   <= {shadow, rx_byte};
                    if (ptr == 2'd2) lo_thresh <= {shadow, rx_byte};
                    if (ptr == 2'd3) hi_thresh <= {shadow, rx_byte};
                  end
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (state == S_PTR) begin
                ptr    <= shift[1:0];
                half   <= 1'b0;
                sda_oe <= 1'b1;
              end else if (state == S_WDATA) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= (shift[7:1] == ADDR);
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (shift[0]) begin
                snapshot <= rd_val;
                half     <= 1'b0;
                bit_cnt  <= 3'd7;
                sda_oe   <= ~rd_val[15];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) sda_oe <= 1'b0;
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
              end else begin
                sda_oe  <= ~tx_byte[bit_cnt - 3'd1];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              master_nack <= sda_s2;
            end else if (scl_fall) begin
              if (master_nack) begin
                sda_oe <= 1'b0;
              end else begin
                bit_cnt <= 3'd7;
                half    <= ~half;
                // After the LSB byte a fresh snapshot keeps each 16-bit
                // read coherent against concurrent conversion updates.
                if (half) begin
                  snapshot <= rd_val;
                  sda_oe   <= ~rd_val[15];
                end else begin
                  sda_oe <= ~snapshot[7];
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs
//   Bit-banged I2C master driving i2c_target_regs over an open-drain SDA
//   line. Directed transactions cover the main scenarios; a randomized
//   phase compares every bus byte and register against a transaction-level
//   model of the register file and pointer.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] conv_data = 16'h0000;
  logic        conv_valid = 1'b0;
  logic [15:0] cfg_reg, lo_thresh, hi_thresh;
  logic        wr_strobe;
  logic [1:0]  wr_ptr;
  logic        busy;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .conv_data(conv_data), .conv_valid(conv_valid), .cfg_reg(cfg_reg),
    .lo_thresh(lo_thresh), .hi_thresh(hi_thresh), .wr_strobe(wr_strobe),
    .wr_ptr(wr_ptr), .busy(busy)
  );

  int assert_count = 0;
  int fail_count = 0;
  int strobe_cnt = 0;
  int oe_cycles = 0;
  logic [1:0] last_wr_ptr = 2'd0;

  // Transaction-level model of the register file
  logic [15:0] m_reg [4];
  logic [1:0]  m_ptr;
  int          m_strobes = 0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_wr_ptr = wr_ptr;
    end
    if (sda_oe) oe_cycles++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetModel();
    m_reg[0] = 16'h0000;
    m_reg[1] = 16'h8583;
    m_reg[2] = 16'h8000;
    m_reg[3] = 16'h7FFF;
    m_ptr = 2'd0;
  endtask

  task automatic busStart();
    waitClk(Q); sda_m = 1'b1;
    waitClk(Q); scl = 1'b1;
    waitClk(2*Q); sda_m = 1'b0;
    waitClk(2*Q); scl = 1'b0;
  endtask

  task automatic busStop();
    waitClk(Q); sda_m = 1'b0;
    waitClk(Q); scl = 1'b1;
    waitClk(2*Q); sda_m = 1'b1;
    waitClk(4*Q);
  endtask

  task automatic sendBit(input logic b, output logic seen);
    waitClk(Q); sda_m = b;
    waitClk(Q); scl = 1'b1;
    waitClk(2*Q); seen = sda_line;
    scl = 1'b0;
  endtask

  // Returns the line level at the 9th clock: 0 = target ACKed
  task automatic writeByte(input logic [7:0] b, output logic ack_line);
    logic [7:0] sh;
    logic dummy;
    sh = b;
    for (int i = 0; i < 8; i++) begin
      sendBit(sh[7], dummy);
      sh = sh << 1;
    end
    sendBit(1'b1, ack_line);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] b);
    logic bit_v;
    logic dummy;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sendBit(1'b1, bit_v);
      b = {b[6:0], bit_v};
    end
    sendBit(nack, dummy);
  endtask

  task automatic pulseConv(input logic [15:0] v);
    conv_data = v; conv_valid = 1'b1;
    waitClk(1);
    conv_valid = 1'b0;
    m_reg[0] = v;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_cfg"}, 32'(cfg_reg), 32'(m_reg[1]));
    checkOutput({tag, "_lo"}, 32'(lo_thresh), 32'(m_reg[2]));
    checkOutput({tag, "_hi"}, 32'(hi_thresh), 32'(m_reg[3]));
    checkOutput({tag, "_strobes"}, 32'(strobe_cnt), 32'(m_strobes));
  endtask

  // One randomized transaction: write, read, conversion update or a
  // foreign address, each checked against the model.
  task automatic applyStimulus();
    int op, n, oe_before;
    logic [1:0] p;
    logic [31:0] wdata;
    logic [7:0] b, sh, rb;
    logic a, acks;
    logic [15:0] v;
    logic [6:0] foreign;
    op = int'($urandom_range(0, 3));
    if (op == 0) begin
      p = 2'($urandom_range(0, 3));
      n = int'($urandom_range(0, 4));
      wdata = $urandom;
      busStart();
      writeByte(8'h90, acks);
      writeByte({6'($urandom), p}, a); acks = acks | a;
      m_ptr = p;
      sh = 8'h00;
      for (int k = 0; k < n; k++) begin
        b = wdata[31:24];
        wdata = wdata << 8;
        writeByte(b, a); acks = acks | a;
        if (k % 2 == 0) begin
          sh = b;
        end else begin
          if (p != 2'd0) m_reg[p] = {sh, b};
          m_strobes++;
        end
      end
      busStop();
      checkOutput("rnd_wr_ack", 32'(acks), 32'd0);
      checkRegs("rnd_wr");
      if (n >= 2) checkOutput("rnd_wr_ptr", 32'(last_wr_ptr), 32'(p));
    end else if (op == 1) begin
      n = int'($urandom_range(1, 4));
      acks = 1'b0;
      busStart();
      if ($urandom_range(0, 1) == 1) begin
        p = 2'($urandom_range(0, 3));
        writeByte(8'h90, a); acks = acks | a;
        writeByte({6'd0, p}, a); acks = acks | a;
        m_ptr = p;
        busStart();
      end
      writeByte(8'h91, a); acks = acks | a;
      checkOutput("rnd_rd_ack", 32'(acks), 32'd0);
      v = m_reg[m_ptr];
      for (int k = 0; k < n; k++) begin
        readByte(k == n - 1, rb);
        checkOutput("rnd_rd_byte", 32'(rb), (k % 2 == 0) ? 32'(v[15:8]) : 32'(v[7:0]));
      end
      busStop();
      checkOutput("rnd_rd_busy", 32'(busy), 32'd0);
    end else if (op == 2) begin
      pulseConv(16'($urandom));
      waitClk(2);
    end else begin
      foreign = 7'($urandom);
      if (foreign == 7'h48) foreign = 7'h49;
      oe_before = oe_cycles;
      busStart();
      writeByte({foreign, 1'($urandom)}, a);
      busStop();
      checkOutput("rnd_foreign_nack", 32'(a), 32'd1);
      checkOutput("rnd_foreign_oe", 32'(oe_cycles - oe_before), 32'd0);
    end
  endtask

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] rb;
    int s0, oe0;

    resetModel();
    reset = 1'b1;
    waitClk(3);
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    checkOutput("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    checkOutput("rst_cfg", 32'(cfg_reg), 32'h8583);
    checkOutput("rst_lo", 32'(lo_thresh), 32'h8000);
    checkOutput("rst_hi", 32'(hi_thresh), 32'h7FFF);
    reset = 1'b0;
    waitClk(5);

    // Write config register
    s0 = strobe_cnt;
    busStart();
    writeByte(8'h90, a0);
    writeByte(8'h01, a1);
    checkOutput("wcfg_busy", 32'(busy), 32'd1);
    writeByte(8'h84, a2);
    writeByte(8'h83, a3);
    busStop();
    checkOutput("wcfg_acks", 32'({a0, a1, a2, a3}), 32'd0);
    checkOutput("wcfg_value", 32'(cfg_reg), 32'h8483);
    checkOutput("wcfg_strobes", 32'(strobe_cnt - s0), 32'd1);
    checkOutput("wcfg_wr_ptr", 32'(last_wr_ptr), 32'd1);
    checkOutput("wcfg_busy_after", 32'(busy), 32'd0);
    m_reg[1] = 16'h8483; m_ptr = 2'd1; m_strobes = m_strobes + 1;

    // Read conversion result through pointer + repeated START
    pulseConv(16'h1234);
    busStart();
    writeByte(8'h90, a0);
    writeByte(8'h00, a1);
    busStart();
    writeByte(8'h91, a2);
    readByte(1'b0, rb);
    checkOutput("rconv_msb", 32'(rb), 32'h12);
    readByte(1'b1, rb);
    checkOutput("rconv_lsb", 32'(rb), 32'h34);
    busStop();
    checkOutput("rconv_acks", 32'({a0, a1, a2}), 32'd0);
    checkOutput("rconv_busy", 32'(busy), 32'd0);
    m_ptr = 2'd0;

    // Foreign address is ignored
    oe0 = oe_cycles;
    busStart();
    writeByte(8'hA0, a0);
    busStop();
    checkOutput("wrongaddr_nack", 32'(a0), 32'd1);
    checkOutput("wrongaddr_oe", 32'(oe_cycles - oe0), 32'd0);
    checkRegs("wrongaddr");

    // Partial write: MSB only, then STOP
    busStart();
    writeByte(8'h90, a0);
    writeByte(8'h02, a1);
    writeByte(8'h55, a2);
    busStop();
    m_ptr = 2'd2;
    checkOutput("partial_acks", 32'({a0, a1, a2}), 32'd0);
    checkOutput("partial_lo", 32'(lo_thresh), 32'h8000);
    checkOutput("partial_strobes", 32'(strobe_cnt), 32'(m_strobes));

    // Snapshot coherence across a conversion update mid-read
    pulseConv(16'hAAAA);
    busStart();
    writeByte(8'h90, a0);
    writeByte(8'h00, a1);
    busStart();
    writeByte(8'h91, a2);
    readByte(1'b0, rb);
    checkOutput("snap_msb", 32'(rb), 32'hAA);
    pulseConv(16'h5555);
    readByte(1'b1, rb);
    checkOutput("snap_lsb", 32'(rb), 32'hAA);
    busStop();
    m_ptr = 2'd0;
    busStart();
    writeByte(8'h91, a0);
    readByte(1'b0, rb);
    checkOutput("snap_next_msb", 32'(rb), 32'h55);
    readByte(1'b1, rb);
    checkOutput("snap_next_lsb", 32'(rb), 32'h55);
    busStop();

    // Randomized phase against the model
    for (int i = 0; i < 30; i++) applyStimulus();

    // Reset while the target drives a 0 data bit
    pulseConv(16'h1234);
    busStart();
    writeByte(8'h90, a0);
    writeByte(8'h00, a1);
    busStart();
    writeByte(8'h91, a2);
    waitClk(Q);
    checkOutput("rstmid_driving", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    waitClk(1);
    checkOutput("rstmid_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_wr_ptr", 32'(wr_ptr), 32'd0);
    checkOutput("rstmid_cfg", 32'(cfg_reg), 32'h8583);
    checkOutput("rstmid_lo", 32'(lo_thresh), 32'h8000);
    checkOutput("rstmid_hi", 32'(hi_thresh), 32'h7FFF);
    reset = 1'b0;
    resetModel();
    busStop();

    // Register 0 and pointer are back to reset values
    busStart();
    writeByte(8'h91, a0);
    readByte(1'b0, rb);
    checkOutput("post_rst_msb", 32'(rb), 32'h00);
    readByte(1'b1, rb);
    checkOutput("post_rst_lsb", 32'(rb), 32'h00);
    busStop();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
